// File: rtl/vga_ram_loader.sv
// Frame-synchronous scanner copying registers, imem and dmem words into
// the VGA display RAM write ports, one read issued per pixel clock.
//
// Ports:
//   clk, rst (async, active low), frame_tick, freeze
//   reg/imem/dmem_rd_addr out, reg/imem/dmem_rd_data in
//   reg/instr/data_mem_{data,addr,enable} out
//   busy, frame_done out
module vga_ram_loader #(
  parameter int          REG_COUNT    = 32,
  parameter int          INSTR_WORDS  = 92,
  parameter int          DATA_WORDS   = 92,
  parameter logic [31:0] INSTR_BASE   = 32'h0000_0000,
  parameter logic [31:0] DATA_BASE    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        freeze,
  output logic [4:0]  reg_rd_addr,
  input  logic [31:0] reg_rd_data,
  output logic [31:0] imem_rd_addr,
  input  logic [31:0] imem_rd_data,
  output logic [31:0] dmem_rd_addr,
  input  logic [31:0] dmem_rd_data,
  output logic [31:0] reg_mem_data,
  output logic [4:0]  reg_mem_addr,
  output logic        reg_mem_enable,
  output logic [31:0] instr_mem_data,
  output logic [6:0]  instr_mem_addr,
  output logic        instr_mem_enable,
  output logic [31:0] data_mem_data,
  output logic [6:0]  data_mem_addr,
  output logic        data_mem_enable,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN_REG,
    SCAN_INSTR,
    SCAN_DATA,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] SRC_REG   = 2'd0;
  localparam logic [1:0] SRC_INSTR = 2'd1;
  localparam logic [1:0] SRC_DATA  = 2'd2;

  localparam logic [6:0] REG_LAST   = 7'(REG_COUNT - 1);
  localparam logic [6:0] INSTR_LAST = 7'(INSTR_WORDS - 1);
  localparam logic [6:0] DATA_LAST  = 7'(DATA_WORDS - 1);
  localparam logic [6:0] DRAIN_LAST = 7'(READ_LATENCY);

  typedef struct packed {
    logic       v;
    logic [1:0] src;
    logic [6:0] idx;
  } tag_t;

  state_t      state_q;
  state_t      state_d;
  logic [6:0]  idx_q;
  logic        pend_q;
  logic        req;
  logic        start;
  logic        iss_reg;
  logic        iss_instr;
  logic        iss_data;
  logic [31:0] instr_cur;
  logic [31:0] data_cur;
  logic [4:0]  reg_addr_q;
  logic [31:0] imem_addr_q;
  logic [31:0] dmem_addr_q;
  tag_t        tag_in;
  tag_t        tag_out;
  tag_t        tag_q [READ_LATENCY];

  assign req     = frame_tick & ~freeze;
  assign start   = (state_d == SCAN_REG) &&
                   (state_q != SCAN_REG);
  assign tag_out = tag_q[READ_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = SCAN_REG;
      SCAN_REG:
        if (idx_q == REG_LAST) state_d = SCAN_INSTR;
      SCAN_INSTR:
        if (idx_q == INSTR_LAST) state_d = SCAN_DATA;
      SCAN_DATA:
        if (idx_q == DATA_LAST) state_d = DRAIN;
      DRAIN:
        if (idx_q == DRAIN_LAST) state_d = DONE;
      DONE:
        state_d = (pend_q || req) ? SCAN_REG : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iss_reg    = (state_q == SCAN_REG);
    iss_instr  = (state_q == SCAN_INSTR);
    iss_data   = (state_q == SCAN_DATA);
    busy       = iss_reg || iss_instr || iss_data ||
                 (state_q == DRAIN);
    frame_done = (state_q == DONE);
    instr_cur  = INSTR_BASE + {23'd0, idx_q, 2'b00};
    data_cur   = DATA_BASE + {23'd0, idx_q, 2'b00};
    // Idle sources keep presenting their last address.
    reg_rd_addr  = iss_reg   ? idx_q[4:0] : reg_addr_q;
    imem_rd_addr = iss_instr ? instr_cur  : imem_addr_q;
    dmem_rd_addr = iss_data  ? data_cur   : dmem_addr_q;
    tag_in.v   = iss_reg || iss_instr || iss_data;
    tag_in.idx = idx_q;
    tag_in.src = iss_reg   ? SRC_REG :
                 iss_instr ? SRC_INSTR : SRC_DATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q            <= '0;
      pend_q           <= 1'b0;
      reg_addr_q       <= '0;
      imem_addr_q      <= '0;
      dmem_addr_q      <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        tag_q[i] <= '0;
      reg_mem_data     <= '0;
      reg_mem_addr     <= '0;
      reg_mem_enable   <= 1'b0;
      instr_mem_data   <= '0;
      instr_mem_addr   <= '0;
      instr_mem_enable <= 1'b0;
      data_mem_data    <= '0;
      data_mem_addr    <= '0;
      data_mem_enable  <= 1'b0;
    end else begin
      if (state_d != state_q || state_q == IDLE)
        idx_q <= '0;
      else
        idx_q <= idx_q + 7'd1;

      // One request can queue behind a running scan.
      if (start)
        pend_q <= 1'b0;
      else if (req && state_q != IDLE)
        pend_q <= 1'b1;

      if (iss_reg)   reg_addr_q  <= idx_q[4:0];
      if (iss_instr) imem_addr_q <= instr_cur;
      if (iss_data)  dmem_addr_q <= data_cur;

      tag_q[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++)
        tag_q[i] <= tag_q[i-1];

      reg_mem_enable   <= 1'b0;
      instr_mem_enable <= 1'b0;
      data_mem_enable  <= 1'b0;
      if (tag_out.v) begin
        case (tag_out.src)
          SRC_REG: begin
            reg_mem_data   <= reg_rd_data;
            reg_mem_addr   <= tag_out.idx[4:0];
            reg_mem_enable <= 1'b1;
          end
          SRC_INSTR: begin
            instr_mem_data   <= imem_rd_data;
            instr_mem_addr   <= tag_out.idx;
            instr_mem_enable <= 1'b1;
          end
          SRC_DATA: begin
            data_mem_data   <= dmem_rd_data;
            data_mem_addr   <= tag_out.idx;
            data_mem_enable <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_ram_loader.sv
// Bench for vga_ram_loader: two instances (latency 1 with offset bases,
// latency 4 with zero bases) checked every cycle against a frame model.
module tb_vga_ram_loader;

  localparam int R = 32;
  localparam int I = 92;
  localparam int D = 92;
  localparam int N = R + I + D;

  logic clk;
  logic rst;
  logic frame_tick;
  logic freeze;
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_f(input logic [31:0] r);
    return 32'hA000_0000 + r;
  endfunction
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] dmem_f(input logic [31:0] a);
    return ~a;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 4;
    localparam logic [31:0] IB =
      (g == 0) ? 32'h0000_0100 : 32'h0;
    localparam logic [31:0] DB =
      (g == 0) ? 32'hFFFF_FFF8 : 32'h0;

    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [31:0] imem_rd_addr;
    logic [31:0] imem_rd_data;
    logic [31:0] dmem_rd_addr;
    logic [31:0] dmem_rd_data;
    logic [31:0] reg_mem_data;
    logic [4:0]  reg_mem_addr;
    logic        reg_mem_enable;
    logic [31:0] instr_mem_data;
    logic [6:0]  instr_mem_addr;
    logic        instr_mem_enable;
    logic [31:0] data_mem_data;
    logic [6:0]  data_mem_addr;
    logic        data_mem_enable;
    logic        busy;
    logic        frame_done;

    vga_ram_loader #(
      .READ_LATENCY(L),
      .INSTR_BASE(IB),
      .DATA_BASE(DB)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .frame_tick(frame_tick),
      .freeze(freeze),
      .reg_rd_addr(reg_rd_addr),
      .reg_rd_data(reg_rd_data),
      .imem_rd_addr(imem_rd_addr),
      .imem_rd_data(imem_rd_data),
      .dmem_rd_addr(dmem_rd_addr),
      .dmem_rd_data(dmem_rd_data),
      .reg_mem_data(reg_mem_data),
      .reg_mem_addr(reg_mem_addr),
      .reg_mem_enable(reg_mem_enable),
      .instr_mem_data(instr_mem_data),
      .instr_mem_addr(instr_mem_addr),
      .instr_mem_enable(instr_mem_enable),
      .data_mem_data(data_mem_data),
      .data_mem_addr(data_mem_addr),
      .data_mem_enable(data_mem_enable),
      .busy(busy),
      .frame_done(frame_done)
    );

    // Source ports: data appears L cycles after the address.
    logic [4:0]  rp [4];
    logic [31:0] ip [4];
    logic [31:0] dp [4];
    always @(posedge clk) begin
      rp[0] <= reg_rd_addr;
      ip[0] <= imem_rd_addr;
      dp[0] <= dmem_rd_addr;
      for (int i = 1; i < 4; i++) begin
        rp[i] <= rp[i-1];
        ip[i] <= ip[i-1];
        dp[i] <= dp[i-1];
      end
    end
    assign reg_rd_data  = reg_f({27'd0, rp[L-1]});
    assign imem_rd_data = imem_f(ip[L-1]);
    assign dmem_rd_data = dmem_f(dp[L-1]);

    int en_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
      en_cnt <= en_cnt + int'(reg_mem_enable) +
                int'(instr_mem_enable) + int'(data_mem_enable);
      done_cnt <= done_cnt + int'(frame_done);
    end

    // Frame model: a scan starting at cycle s issues item d in
    // cycle s+d, writes it in s+d+L+1 and reports done in s+N+L+1.
    bit m_act;
    bit m_pend;
    int m_s;
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_act  = 1'b0;
        m_pend = 1'b0;
        m_s    = 0;
      end else if (!m_act) begin
        if (frame_tick && !freeze) begin
          m_act = 1'b1;
          m_s   = cyc + 1;
        end
      end else if (cyc - m_s == N + L + 1) begin
        if (m_pend || (frame_tick && !freeze)) begin
          m_s    = cyc + 1;
          m_pend = 1'b0;
        end else begin
          m_act = 1'b0;
        end
      end else if (frame_tick && !freeze) begin
        m_pend = 1'b1;
      end
    end

    logic [4:0]  h_ra;
    logic [31:0] h_ia, h_da;
    logic [4:0]  h_rwa;
    logic [6:0]  h_iwa, h_dwa;
    logic [31:0] h_rwd, h_iwd, h_dwd;
    logic e_ren, e_ien, e_den, e_busy, e_done;
    always @(negedge clk) begin
      int d;
      int j;
      e_ren = 0; e_ien = 0; e_den = 0;
      e_busy = 0; e_done = 0;
      if (!rst) begin
        h_ra = 0; h_ia = 0; h_da = 0;
        h_rwa = 0; h_iwa = 0; h_dwa = 0;
        h_rwd = 0; h_iwd = 0; h_dwd = 0;
      end else if (m_act && cyc >= m_s) begin
        d = cyc - m_s;
        if (d < R)
          h_ra = 5'(d);
        else if (d < R + I)
          h_ia = IB + 32'(4 * (d - R));
        else if (d < N)
          h_da = DB + 32'(4 * (d - R - I));
        e_busy = (d <= N + L);
        e_done = (d == N + L + 1);
        j = d - L - 1;
        if (j >= 0 && j < R) begin
          e_ren = 1;
          h_rwa = 5'(j);
          h_rwd = reg_f(32'(j));
        end else if (j >= R && j < R + I) begin
          e_ien = 1;
          h_iwa = 7'(j - R);
          h_iwd = imem_f(IB + 32'(4 * (j - R)));
        end else if (j >= R + I && j < N) begin
          e_den = 1;
          h_dwa = 7'(j - R - I);
          h_dwd = dmem_f(DB + 32'(4 * (j - R - I)));
        end
      end
      check($sformatf("L%0d ctl", L),
            {busy, frame_done, reg_mem_enable,
             instr_mem_enable, data_mem_enable},
            {e_busy, e_done, e_ren, e_ien, e_den});
      check($sformatf("L%0d rd_addr", L),
            {reg_rd_addr, imem_rd_addr, dmem_rd_addr},
            {h_ra, h_ia, h_da});
      check($sformatf("L%0d reg_wr", L),
            {reg_mem_addr, reg_mem_data}, {h_rwa, h_rwd});
      check($sformatf("L%0d instr_wr", L),
            {instr_mem_addr, instr_mem_data}, {h_iwa, h_iwd});
      check($sformatf("L%0d data_wr", L),
            {data_mem_addr, data_mem_data}, {h_dwa, h_dwd});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse(output int t);
    frame_tick = 1'b1;
    t = cyc;
    step();
    frame_tick = 1'b0;
  endtask

  int t0;
  int tx;
  int e0;
  int e1;
  int d0;
  int d1;

  initial begin
    rst = 1'b0;
    frame_tick = 1'b0;
    freeze = 1'b0;
    repeat (3) step();
    check("reset_outs",
          {g_dut[0].busy, g_dut[0].frame_done,
           g_dut[0].reg_mem_enable, g_dut[0].reg_rd_addr,
           g_dut[0].imem_rd_addr, g_dut[0].reg_mem_data},
          '0);
    rst = 1'b1;
    repeat (3) step();

    // Basic scan with literal timing and address points.
    e0 = g_dut[0].en_cnt;
    e1 = g_dut[1].en_cnt;
    pulse(t0);
    at_cycle(t0 + 3);
    check("l1_first_reg",
          {g_dut[0].reg_mem_enable, g_dut[0].reg_mem_addr,
           g_dut[0].reg_mem_data},
          {1'b1, 5'd0, 32'hA000_0000});
    check("l4_no_early_wr", g_dut[1].reg_mem_enable, 0);
    at_cycle(t0 + 6);
    check("l4_first_reg",
          {g_dut[1].reg_mem_enable, g_dut[1].reg_mem_addr},
          {1'b1, 5'd0});
    at_cycle(t0 + 33);
    check("instr_addr0", g_dut[0].imem_rd_addr, 32'h100);
    at_cycle(t0 + 34);
    check("last_reg",
          {g_dut[0].reg_mem_enable, g_dut[0].reg_mem_addr,
           g_dut[0].reg_mem_data},
          {1'b1, 5'd31, 32'hA000_001F});
    at_cycle(t0 + 35);
    check("first_instr",
          {g_dut[0].instr_mem_enable, g_dut[0].instr_mem_addr,
           g_dut[0].instr_mem_data},
          {1'b1, 7'd0, 32'h5A5A_0100});
    at_cycle(t0 + 124);
    check("instr_addr91", g_dut[0].imem_rd_addr, 32'h26C);
    at_cycle(t0 + 125);
    check("data_addr0", g_dut[0].dmem_rd_addr, 32'hFFFF_FFF8);
    at_cycle(t0 + 127);
    check("data_addr_wrap", g_dut[0].dmem_rd_addr, 32'h0);
    check("first_data",
          {g_dut[0].data_mem_enable, g_dut[0].data_mem_addr,
           g_dut[0].data_mem_data},
          {1'b1, 7'd0, 32'h0000_0007});
    at_cycle(t0 + 218);
    check("last_data",
          {g_dut[0].busy, g_dut[0].data_mem_enable,
           g_dut[0].data_mem_addr, g_dut[0].data_mem_data},
          {1'b1, 1'b1, 7'd91, 32'hFFFF_FE9B});
    at_cycle(t0 + 219);
    check("l1_done",
          {g_dut[0].frame_done, g_dut[0].busy}, 2'b10);
    at_cycle(t0 + 222);
    check("l4_done",
          {g_dut[1].frame_done, g_dut[1].busy}, 2'b10);
    at_cycle(t0 + 240);
    check("l1_writes", g_dut[0].en_cnt - e0, N);
    check("l4_writes", g_dut[1].en_cnt - e1, N);

    // Three ticks during a scan give exactly one rescan.
    d0 = g_dut[0].done_cnt;
    d1 = g_dut[1].done_cnt;
    pulse(t0);
    at_cycle(t0 + 20);
    pulse(tx);
    at_cycle(t0 + 60);
    pulse(tx);
    at_cycle(t0 + 100);
    pulse(tx);
    at_cycle(t0 + 220);
    check("rescan_busy",
          {g_dut[0].busy, g_dut[0].reg_rd_addr}, {1'b1, 5'd0});
    at_cycle(t0 + 222);
    check("rescan_wr",
          {g_dut[0].reg_mem_enable, g_dut[0].reg_mem_data},
          {1'b1, 32'hA000_0000});
    at_cycle(t0 + 438);
    check("rescan_done", g_dut[0].frame_done, 1);
    at_cycle(t0 + 700);
    check("l1_two_scans", g_dut[0].done_cnt - d0, 2);
    check("l4_two_scans", g_dut[1].done_cnt - d1, 2);
    check("idle_after", g_dut[0].busy, 0);

    // Frozen tick is ignored.
    freeze = 1'b1;
    e0 = g_dut[0].en_cnt;
    pulse(t0);
    at_cycle(t0 + 30);
    check("freeze_busy",
          {g_dut[0].busy, g_dut[1].busy}, 2'b00);
    check("freeze_no_wr", g_dut[0].en_cnt - e0, 0);
    freeze = 1'b0;
    step();

    // Freeze raised mid-scan: scan completes, no pending recorded.
    e0 = g_dut[0].en_cnt;
    e1 = g_dut[1].en_cnt;
    d0 = g_dut[0].done_cnt;
    pulse(t0);
    at_cycle(t0 + 10);
    freeze = 1'b1;
    at_cycle(t0 + 50);
    pulse(tx);
    at_cycle(t0 + 500);
    check("frz_mid_l1", g_dut[0].en_cnt - e0, N);
    check("frz_mid_l4", g_dut[1].en_cnt - e1, N);
    check("frz_mid_done", g_dut[0].done_cnt - d0, 1);
    freeze = 1'b0;
    step();

    // Reset mid-scan.
    pulse(t0);
    at_cycle(t0 + 50);
    rst = 1'b0;
    step();
    check("rst_outs",
          {g_dut[0].busy, g_dut[0].reg_rd_addr,
           g_dut[0].imem_rd_addr, g_dut[0].dmem_rd_addr,
           g_dut[0].reg_mem_data, g_dut[0].reg_mem_addr,
           g_dut[0].reg_mem_enable},
          '0);
    step();
    rst = 1'b1;
    e0 = g_dut[0].en_cnt;
    e1 = g_dut[1].en_cnt;
    repeat (100) step();
    check("rst_no_wr_l1", g_dut[0].en_cnt - e0, 0);
    check("rst_no_wr_l4", g_dut[1].en_cnt - e1, 0);
    pulse(t0);
    at_cycle(t0 + 3);
    check("rst_restart",
          {g_dut[0].reg_mem_enable, g_dut[0].reg_mem_addr,
           g_dut[0].reg_mem_data},
          {1'b1, 5'd0, 32'hA000_0000});
    at_cycle(t0 + 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
